// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-memory writer path.
package rv_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    FILL,
    DONE,
    ERR
  } loader_state_e;

  function automatic logic state_busy(loader_state_e s);
    return (s == HDR0) || (s == HDR1) || (s == DATA) || (s == FILL);
  endfunction

  // Only the header and payload states take bytes from the source.
  function automatic logic state_ready(loader_state_e s);
    return (s == HDR0) || (s == HDR1) || (s == DATA);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects four bytes LSB-first into one word; flags the cycle the fourth byte arrives.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word_c,
  output logic        word_valid_c
);

  logic [23:0] lo_q, lo_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    lo_d  = lo_q;
    idx_d = idx_q;
    if (clear) begin
      lo_d  = 24'd0;
      idx_d = 2'd0;
    end else if (accept) begin
      case (idx_q)
        2'd0:    lo_d[7:0]   = data;
        2'd1:    lo_d[15:8]  = data;
        2'd2:    lo_d[23:16] = data;
        default: lo_d        = lo_q;
      endcase
      idx_d = idx_q + 2'd1;
    end
  end

  // The top byte is taken straight from the bus so the word is ready on the accept edge.
  assign word_c       = {data, lo_q};
  assign word_valid_c = accept && !clear && (idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q  <= 24'd0;
      idx_q <= 2'd0;
    end else begin
      lo_q  <= lo_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed little-endian byte stream into instruction memory, then pads the rest with NOPs.
module imem_loader #(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [31:0] NOP_WORD = rv_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned WIDX_W = $clog2(DEPTH) + 1;

  rv_pkg::loader_state_e state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [WIDX_W-1:0] word_idx_q, word_idx_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic        accept_c;
  logic        pk_clear_c;
  logic        pk_accept_c;
  logic [31:0] pk_word_c;
  logic        pk_word_valid_c;
  logic [15:0] hdr_n_c;
  logic        last_word_c;

  assign accept_c    = in_valid && in_ready_q;
  assign pk_accept_c = accept_c && (state_q == rv_pkg::DATA);
  assign hdr_n_c     = {in_data, n_q[7:0]};
  assign last_word_c = (32'(word_idx_q) + 32'd1) == 32'(n_q);

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (pk_clear_c),
    .accept       (pk_accept_c),
    .data         (in_data),
    .word_c       (pk_word_c),
    .word_valid_c (pk_word_valid_c)
  );

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    word_idx_d  = word_idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    error_d     = error_q;
    pk_clear_c  = 1'b0;

    case (state_q)
      rv_pkg::IDLE, rv_pkg::DONE, rv_pkg::ERR: begin
        if (start) begin
          state_d    = rv_pkg::HDR0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          n_d        = 16'd0;
          word_idx_d = '0;
          pk_clear_c = 1'b1;
        end
      end
      rv_pkg::HDR0: begin
        if (accept_c) begin
          n_d[7:0] = in_data;
          state_d  = rv_pkg::HDR1;
        end
      end
      rv_pkg::HDR1: begin
        if (accept_c) begin
          n_d = hdr_n_c;
          if (32'(hdr_n_c) > DEPTH) begin
            state_d = rv_pkg::ERR;
            error_d = 1'b1;
          end else if (hdr_n_c == 16'd0) begin
            state_d = rv_pkg::FILL;
          end else begin
            state_d = rv_pkg::DATA;
          end
        end
      end
      rv_pkg::DATA: begin
        if (pk_word_valid_c) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = 32'(word_idx_q) << 2;
          mem_wdata_d = pk_word_c;
          word_idx_d  = word_idx_q + WIDX_W'(1);
          if (last_word_c) begin
            state_d = (32'(n_q) == DEPTH) ? rv_pkg::DONE : rv_pkg::FILL;
          end
        end
      end
      rv_pkg::FILL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = 32'(word_idx_q) << 2;
        mem_wdata_d = NOP_WORD;
        word_idx_d  = word_idx_q + WIDX_W'(1);
        if (32'(word_idx_q) == DEPTH - 1) begin
          state_d = rv_pkg::DONE;
        end
      end
      default: state_d = rv_pkg::IDLE;
    endcase

    // done rises one cycle after the final write, i.e. once DONE has been held for a cycle.
    if ((state_q == rv_pkg::DONE) && (state_d == rv_pkg::DONE)) begin
      done_d = 1'b1;
    end

    in_ready_d = rv_pkg::state_ready(state_d);
    busy_d     = rv_pkg::state_busy(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= rv_pkg::IDLE;
      n_q         <= 16'd0;
      word_idx_q  <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      word_idx_q  <= word_idx_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to instruction_memory.
- Accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and drives a synchronous write port into instruction memory.
- After the payload, fills the remainder of memory with NOP, then reports completion so the core can be released from reset/stall.
- Sits between the host byte source (UART/debug bridge) and instruction_memory's write port.

Parameters:
- DEPTH, 1024, instruction memory size in 32-bit words; bench uses 8.
- NOP_WORD, 32'h00000013, fill value (ADDI x0, x0, 0).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse to begin a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  byte source has a byte.
- in_data  input  8  byte value.
- in_ready  output  1  loader accepts a byte; transfer occurs when in_valid && in_ready at a rising edge.
- mem_we  output  1  write strobe to instruction memory, one word per asserted cycle.
- mem_addr  output  32  byte address of the word, always word-aligned (word_idx*4).
- mem_wdata  output  32  word to write.
- busy  output  1  high in HDR0, HDR1, DATA and FILL.
- done  output  1  load completed successfully; sticky until next accepted start.
- error  output  1  header word count exceeded DEPTH; sticky until next accepted start.

Behaviour:
- One clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; in_ready, mem_we, busy, done and error = 0; mem_addr and mem_wdata = 0. The byte counter, word counter and N also clear.
- Frame format: 2-byte word count N, LSB first, then N*4 payload bytes. Each word is LSB first: byte0 = wdata[7:0] … byte3 = wdata[31:24].
- States and transitions:
  - IDLE / DONE / ERR: start -> HDR0; clear done and error.
  - HDR0: in_ready=1; on accept latch N[7:0] -> HDR1.
  - HDR1: in_ready=1; on accept latch N[15:8], then:
    - N > DEPTH: -> ERR; set error.
    - N == 0: -> FILL.
    - otherwise: -> DATA.
  - DATA: in_ready=1; byte index 0..3 wraps. On accepting byte 3:
    - Next cycle: mem_we=1, mem_wdata = assembled word, mem_addr = word_idx*4; word_idx increments.
    - If that was word N-1: go to FILL, or to DONE when N == DEPTH.
  - FILL: in_ready=0; one NOP_WORD write per cycle at word_idx, for word_idx = N … DEPTH-1.
    - After the DEPTH-1 write -> DONE; done=1 in the following cycle.
- Write timing:
  - mem_we is registered and is a single-cycle pulse per word.
  - Back-to-back byte streaming gives one write every 4 cycles in DATA; FILL writes every cycle.
  - No stall from memory: the write port always accepts.
- in_ready is a registered function of state. in_valid while in_ready=0 is ignored; no byte is consumed.
- A stalled source (in_valid low) holds the partial word, byte index and state indefinitely.
- start while busy is ignored.
- In ERR: no writes, in_ready=0.
- Each word address is written exactly once per load.
- Asynchronous reset mid-load: immediately IDLE, mem_we deasserted. Memory contents are left partially written; a new start is required.
- word_idx width is $clog2(DEPTH)+1 so that DEPTH is representable. mem_addr is zero-extended to 32 bits.

Decomposition:
- Shared package rv_pkg holds NOP_WORD (shared with instruction_memory) and the loader state enum loader_state_e {IDLE, HDR0, HDR1, DATA, FILL, DONE, ERR}.
- One natural sub-module, byte_packer: 4-byte shift/assemble register with byte index and word_valid pulse. The FSM and counters stay in imem_loader.

Test Plan:
- DEPTH=8; start; bytes 03 00, then 93 00 50 00, 13 01 A0 00, B3 81 20 00 -> writes (0x0,00500093), (0x4,00A00113), (0x8,002081B3), then NOP 00000013 at 0xC…0x1C. done=1 one cycle after the 0x1C write; exactly 8 mem_we pulses.
- N=0 (bytes 00 00) -> eight NOP writes to 0x0…0x1C on consecutive cycles, then done=1. in_ready=0 throughout FILL.
- N=9 (bytes 09 00) -> error=1, no mem_we, in_ready=0. A later start with N=1 clears error and loads normally.
- Same frame as the first test with in_valid randomly dropped between bytes -> identical write sequence and data. No byte is consumed while in_ready=0.
- Assert rst_n low in DATA after 2 bytes of word 1 -> immediately in_ready, mem_we, busy, done and error = 0. A new start plus the full 1-word frame (N=1, 13 00 00 00) writes 0x00000013 at 0x0, then 7 NOPs.
- start pulsed while busy mid-DATA -> ignored; load completes as with no extra start. N=8 (DEPTH) -> 8 data writes, no FILL writes, done=1.
